// File: rtl/batchflow_pkg.sv
// Shared types for the batchflow task dispatcher.
// Holds the FSM encoding and the task-slot limits.
package batchflow_pkg;

    localparam int MAX_TASKS = 32;

    typedef logic [$clog2(MAX_TASKS)-1:0] task_id_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ERR
    } disp_state_e;

endpackage

// File: rtl/task_dispatcher_if.sv
// Issue and completion ports between the dispatcher
// and the task cells it launches.
interface task_dispatcher_if #(
    parameter int N_TASKS = 8
);
    localparam int IDW = $clog2(N_TASKS);

    logic           issue_valid;
    logic           issue_ready;
    logic [IDW-1:0] issue_id;
    logic           done_valid;
    logic [IDW-1:0] done_id;

    modport master (
        output issue_valid,
        output issue_id,
        input  issue_ready,
        input  done_valid,
        input  done_id
    );

    modport slave (
        input  issue_valid,
        input  issue_id,
        output issue_ready,
        output done_valid,
        output done_id
    );

endinterface

// File: rtl/prio_pick.sv
// Lowest-index request picker: one-hot grant,
// encoded index and any-request flag.
module prio_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    assign onehot = req & (~req + N'(1));
    assign any    = |req;

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/task_dispatcher.sv
// Dependency-ordered task issuer for a batchflow graph:
// predecessor masks in, task IDs out, completions retire.
module task_dispatcher
    import batchflow_pkg::*;
#(
    parameter  int N_TASKS = 8,
    parameter  int MAX_OUT = 4,
    localparam int IDW     = $clog2(N_TASKS),
    localparam int OW      = $clog2(MAX_OUT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [IDW-1:0]     cfg_id,
    input  logic               cfg_en,
    input  logic [N_TASKS-1:0] cfg_pred,
    input  logic               start,
    task_dispatcher_if.master  io,
    output logic               busy,
    output logic               finish,
    output logic               err_deadlock,
    output logic               err_spurious
);

    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUT);

    disp_state_e        state_q, state_d;
    logic [N_TASKS-1:0] en_q, en_d;
    logic [N_TASKS-1:0] pred_q [N_TASKS];
    logic [N_TASKS-1:0] pred_d [N_TASKS];
    logic [N_TASKS-1:0] issued_q, issued_d;
    logic [N_TASKS-1:0] completed_q, completed_d;
    logic [OW-1:0]      out_q, out_d;
    logic               iv_q, iv_d;
    logic [IDW-1:0]     iid_q, iid_d;
    logic               dl_q, dl_d;
    logic               sp_q, sp_d;
    logic               fin_q, fin_d;

    logic [N_TASKS-1:0] rdy;
    logic [N_TASKS-1:0] pick_oh;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic               hs;
    logic               done_ok;
    logic               all_done;

    // Disabled predecessors count as satisfied.
    always_comb begin
        for (int i = 0; i < N_TASKS; i++) begin
            rdy[i] = en_q[i] & ~issued_q[i]
                   & ~|(pred_q[i] & en_q & ~completed_q);
        end
    end

    prio_pick #(
        .N (N_TASKS)
    ) u_pick (
        .req    (rdy),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign hs       = iv_q & io.issue_ready;
    assign all_done = ~|(en_q & ~completed_q);

    // A task still waiting on its handshake is not yet outstanding.
    assign done_ok = io.done_valid
                   & issued_q[io.done_id]
                   & ~completed_q[io.done_id]
                   & ~(iv_q && iid_q == io.done_id);

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        pred_d      = pred_q;
        issued_d    = issued_q;
        completed_d = completed_q;
        out_d       = out_q;
        iv_d        = iv_q;
        iid_d       = iid_q;
        dl_d        = dl_q;
        sp_d        = sp_q;
        fin_d       = 1'b0;

        if (hs) begin
            iv_d  = 1'b0;
            out_d = out_d + OW'(1);
        end
        if (done_ok) begin
            completed_d[io.done_id] = 1'b1;
            out_d = out_d - OW'(1);
        end else if (io.done_valid) begin
            sp_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    en_d[cfg_id]   = cfg_en;
                    pred_d[cfg_id] = cfg_pred;
                end
            end
            RUN: begin
                if (all_done) begin
                    state_d = IDLE;
                    fin_d   = 1'b1;
                end else if (!iv_q && pick_any && out_q < MAX_O) begin
                    iv_d     = 1'b1;
                    iid_d    = pick_idx;
                    issued_d = issued_q | pick_oh;
                end else if (!iv_q && !pick_any && out_q == '0) begin
                    state_d = ERR;
                    dl_d    = 1'b1;
                end
            end
            ERR: begin
            end
            default: state_d = IDLE;
        endcase

        if (start && state_q != RUN) begin
            state_d     = RUN;
            issued_d    = '0;
            completed_d = '0;
            out_d       = '0;
            iv_d        = 1'b0;
            dl_d        = 1'b0;
            sp_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            en_q        <= '0;
            for (int i = 0; i < N_TASKS; i++) pred_q[i] <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            out_q       <= '0;
            iv_q        <= 1'b0;
            iid_q       <= '0;
            dl_q        <= 1'b0;
            sp_q        <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            pred_q      <= pred_d;
            issued_q    <= issued_d;
            completed_q <= completed_d;
            out_q       <= out_d;
            iv_q        <= iv_d;
            iid_q       <= iid_d;
            dl_q        <= dl_d;
            sp_q        <= sp_d;
            fin_q       <= fin_d;
        end
    end

    assign io.issue_valid = iv_q;
    assign io.issue_id    = iid_q;
    assign busy           = (state_q == RUN);
    assign finish         = fin_q;
    assign err_deadlock   = dl_q;
    assign err_spurious   = sp_q;

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher: graph table plus
// hand sequences for back-pressure and mid-run reset.
module tb_task_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_id;
    logic       cfg_en;
    logic [7:0] cfg_pred;
    logic       start;
    logic       rdy;
    logic       done_valid;
    logic [2:0] done_id;
    logic       sel;

    logic busy0, fin0, dl0, sp0;
    logic busy1, fin1, dl1, sp1;
    logic       d_iv, d_busy, d_fin, d_dl, d_sp;
    logic [2:0] d_iid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task_dispatcher_if #(.N_TASKS(8)) if0 ();
    task_dispatcher_if #(.N_TASKS(8)) if1 ();

    assign if0.issue_ready = rdy;
    assign if0.done_valid  = done_valid;
    assign if0.done_id     = done_id;
    assign if1.issue_ready = rdy;
    assign if1.done_valid  = done_valid;
    assign if1.done_id     = done_id;

    task_dispatcher #(.N_TASKS(8), .MAX_OUT(4)) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_id       (cfg_id),
        .cfg_en       (cfg_en),
        .cfg_pred     (cfg_pred),
        .start        (start),
        .io           (if0),
        .busy         (busy0),
        .finish       (fin0),
        .err_deadlock (dl0),
        .err_spurious (sp0)
    );

    task_dispatcher #(.N_TASKS(8), .MAX_OUT(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_id       (cfg_id),
        .cfg_en       (cfg_en),
        .cfg_pred     (cfg_pred),
        .start        (start),
        .io           (if1),
        .busy         (busy1),
        .finish       (fin1),
        .err_deadlock (dl1),
        .err_spurious (sp1)
    );

    always_comb begin
        d_iv   = sel ? if1.issue_valid : if0.issue_valid;
        d_iid  = sel ? if1.issue_id    : if0.issue_id;
        d_busy = sel ? busy1 : busy0;
        d_fin  = sel ? fin1  : fin0;
        d_dl   = sel ? dl1   : dl0;
        d_sp   = sel ? sp1   : sp0;
    end

    typedef struct {
        logic [7:0]  en;
        logic [63:0] pred;
        logic        sel;
        logic        spur;
        int          n;
        logic [31:0] ord;
        logic        dl;
        logic        fin;
    } vec_t;

    vec_t tbl [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_id     = '0;
        cfg_en     = 1'b0;
        cfg_pred   = '0;
        start      = 1'b0;
        rdy        = 1'b0;
        done_valid = 1'b0;
        done_id    = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic cfg_write(input logic [7:0] en,
                             input logic [63:0] pred);
        for (int i = 0; i < 8; i++) begin
            cfg_we   = 1'b1;
            cfg_id   = 3'(i);
            cfg_en   = en[i];
            cfg_pred = pred[i*8 +: 8];
            step();
        end
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_issue(input logic [2:0] exp,
                              input string nm);
        for (int k = 0; k < 20 && !d_iv; k++) step();
        check(nm, {d_iv, d_iid}, {1'b1, exp});
    endtask

    task automatic run_vec(input vec_t v, input int r);
        int          n;
        logic [31:0] ord;
        logic [7:0]  pend;
        int          due [8];
        int          fin_cnt;
        int          dl_cyc;
        int          outs;
        int          mx;
        logic        hs_now;
        logic [2:0]  id_now;
        string       tag;

        sel = v.sel;
        do_reset();
        cfg_write(v.en, v.pred);
        pulse_start();
        n = 0; ord = '0; pend = '0;
        fin_cnt = 0; dl_cyc = -1; outs = 0; mx = 0;
        rdy = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (d_fin) fin_cnt++;
            if (d_dl && dl_cyc < 0) dl_cyc = c;
            hs_now = d_iv;
            id_now = d_iid;
            done_valid = 1'b0;
            done_id    = '0;
            if (v.spur && c == 0) begin
                done_valid = 1'b1;
                done_id    = 3'd5;
            end else begin
                for (int j = 0; j < 8; j++) begin
                    if (!done_valid && pend[j] && due[j] <= c) begin
                        done_valid = 1'b1;
                        done_id    = 3'(j);
                        pend[j]    = 1'b0;
                        outs--;
                    end
                end
            end
            if (hs_now) begin
                if (n < 8) ord[n*4 +: 4] = 4'(id_now);
                n++;
                pend[id_now] = 1'b1;
                due[id_now]  = c + 3;
                outs++;
                if (outs > mx) mx = outs;
            end
            step();
        end
        done_valid = 1'b0;
        rdy        = 1'b0;
        tag = $sformatf("row%0d", r);
        check({tag, "_count"}, 64'(n), 64'(v.n));
        check({tag, "_order"}, ord, v.ord);
        check({tag, "_finish"}, 64'(fin_cnt), {63'd0, v.fin});
        check({tag, "_deadlock"}, d_dl, v.dl);
        check({tag, "_spurious"}, d_sp, v.spur);
        check({tag, "_busy"}, d_busy, 1'b0);
        check({tag, "_maxout"}, (mx <= (v.sel ? 1 : 4)), 1'b1);
        if (v.dl && v.n == 0)
            check({tag, "_dl_lat"},
                  (dl_cyc >= 0 && dl_cyc <= 3), 1'b1);
    endtask

    initial begin
        int hsn;
        logic found;

        tbl[0]  = '{8'h07, 64'h0000_0000_0003_0000, 0, 0, 3, 32'h210, 0, 1};
        tbl[1]  = '{8'h0F, 64'h0, 0, 0, 4, 32'h3210, 0, 1};
        tbl[2]  = '{8'h0F, 64'h0000_0000_0402_0008, 0, 0, 4, 32'h0321, 0, 1};
        tbl[3]  = '{8'h05, 64'h0000_0000_0002_0000, 0, 0, 2, 32'h20, 0, 1};
        tbl[4]  = '{8'h03, 64'h0000_0000_0000_0102, 0, 0, 0, 32'h0, 1, 0};
        tbl[5]  = '{8'h03, 64'h0000_0000_0000_0100, 0, 0, 2, 32'h10, 0, 1};
        tbl[6]  = '{8'h01, 64'h0000_0000_0000_0001, 0, 0, 0, 32'h0, 1, 0};
        tbl[7]  = '{8'h07, 64'h0000_0000_0002_0400, 0, 0, 1, 32'h0, 1, 0};
        tbl[8]  = '{8'h00, 64'h0, 0, 0, 0, 32'h0, 0, 1};
        tbl[9]  = '{8'hF0, 64'h6010_1000_0000_0000, 0, 0, 4, 32'h7654, 0, 1};
        tbl[10] = '{8'h07, 64'h0, 0, 1, 3, 32'h210, 0, 1};
        tbl[11] = '{8'h0F, 64'h0, 1, 0, 4, 32'h3210, 0, 1};

        sel = 1'b0;
        do_reset();
        check("reset_outputs",
              {d_iv, d_iid, d_busy, d_fin, d_dl, d_sp}, '0);

        for (int r = 0; r < 12; r++) run_vec(tbl[r], r);

        // Back-pressure: task 1 becomes ready behind pending task 2.
        sel = 1'b0;
        do_reset();
        cfg_write(8'h07, 64'h0000_0000_0000_0100);
        pulse_start();
        rdy = 1'b1;
        wait_issue(3'd0, "hold_first");
        step();
        rdy = 1'b0;
        wait_issue(3'd2, "hold_second");
        done_valid = 1'b1;
        done_id    = 3'd0;
        step();
        done_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("hold_stable", {d_iv, d_iid}, {1'b1, 3'd2});
            step();
        end
        rdy = 1'b1;
        step();
        wait_issue(3'd1, "hold_after");
        step();
        rdy = 1'b0;
        done_valid = 1'b1;
        done_id    = 3'd2;
        step();
        done_id    = 3'd1;
        step();
        done_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (d_fin) found = 1'b1;
            else step();
        end
        check("hold_finish", found, 1'b1);
        check("hold_spurious", d_sp, 1'b0);

        // Asynchronous reset with two tasks outstanding.
        do_reset();
        cfg_write(8'h03, 64'h0);
        pulse_start();
        rdy = 1'b1;
        hsn = 0;
        for (int k = 0; k < 20 && hsn < 2; k++) begin
            if (d_iv) hsn++;
            step();
        end
        check("rst_two_hs", 64'(hsn), 64'd2);
        rdy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async",
              {d_iv, d_iid, d_busy, d_fin, d_dl, d_sp}, '0);
        rst = 1'b0;
        step();
        pulse_start();
        check("rst_busy", d_busy, 1'b1);
        step();
        check("rst_finish", {d_fin, d_busy}, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
